unsigned_sqrt_multibit: RTL and testbench

//  Iterative unsigned integer square root, restoring digit-recurrence.

---
 rtl/unsigned_sqrt_multibit.sv | 118 +++++++++++
 tb/tb_unsigned_sqrt_multibit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_sqrt_multibit.sv
// Iterative unsigned integer square root (restoring digit recurrence).
// Retires BITS_PER_CYCLE root bits per cycle; ready/done handshake with abort and a zero fast path.
module unsigned_sqrt_multibit #(
    parameter int DATA_WIDTH     = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   radicand,
    input  logic                    abort,
    output logic                    ready,
    output logic                    done,
    output logic [DATA_WIDTH/2-1:0] result,
    output logic [DATA_WIDTH/2:0]   remainder
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam int N    = HALF / BITS_PER_CYCLE;
    localparam int CW   = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rad_sh;
    logic [HALF-1:0]       root_q;
    logic [HALF:0]         rem_q;

    logic [HALF-1:0]       root_next;
    logic [HALF:0]         rem_next;
    logic [HALF+1:0]       trial;
    logic [HALF+1:0]       sub;
    logic [HALF+1:0]       diff;
    logic                  borrow;

    // The partial remainder never exceeds twice the partial root, so its
    // top bit is always clear when it is shifted into the trial value.
    always_comb begin
        root_next = root_q;
        rem_next  = rem_q;
        trial     = '0;
        sub       = '0;
        diff      = '0;
        borrow    = 1'b0;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            trial  = {rem_next[HALF-1:0], rad_sh[DATA_WIDTH-1-2*s -: 2]};
            sub    = {root_next, 2'b01};
            diff   = trial - sub;
            borrow = (trial < sub);
            if (borrow) rem_next = trial[HALF:0];
            else        rem_next = diff[HALF:0];
            root_next = {root_next[HALF-2:0], ~borrow};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            cnt       <= '0;
            rad_sh    <= '0;
            root_q    <= '0;
            rem_q     <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ready <= 1'b0;
                            if (radicand == '0) begin
                                state     <= DONE;
                                done      <= 1'b1;
                                result    <= '0;
                                remainder <= '0;
                            end else begin
                                state  <= BUSY;
                                rad_sh <= radicand;
                                root_q <= '0;
                                rem_q  <= '0;
                                cnt    <= '0;
                            end
                        end
                    end
                    BUSY: begin
                        root_q <= root_next;
                        rem_q  <= rem_next;
                        rad_sh <= rad_sh << (2 * BITS_PER_CYCLE);
                        if (cnt == CW'(N - 1)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= root_next;
                            remainder <= rem_next;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unsigned_sqrt_multibit.sv
// Directed and random bench for unsigned_sqrt_multibit at 32 bits with 1, 2 and 4 bits per cycle.
// All three variants share stimulus and are checked side by side.
module tb_unsigned_sqrt_multibit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] radicand = '0;

    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [15:0] res_v [3];
    logic [16:0] rem_v [3];

    int n_vec = 0;
    int n_bad = 0;
    int lat [3] = '{17, 9, 5};

    int          got_cyc [3];
    int          pulses  [3];
    logic [15:0] got_res [3];
    logic [16:0] got_rem [3];
    logic        rdy_post [3];
    logic        rdy_snap [3];

    always #5 clk = ~clk;

    unsigned_sqrt_multibit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst(rst), .start(start), .radicand(radicand), .abort(abort),
        .ready(ready_v[0]), .done(done_v[0]), .result(res_v[0]), .remainder(rem_v[0]));
    unsigned_sqrt_multibit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(2)) u_b2 (
        .clk(clk), .rst(rst), .start(start), .radicand(radicand), .abort(abort),
        .ready(ready_v[1]), .done(done_v[1]), .result(res_v[1]), .remainder(rem_v[1]));
    unsigned_sqrt_multibit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst(rst), .start(start), .radicand(radicand), .abort(abort),
        .ready(ready_v[2]), .done(done_v[2]), .result(res_v[2]), .remainder(rem_v[2]));

    // Start is high in cycle 0; cycle k is the window just after the k-th following edge.
    // ign_cyc pulses start again; abort is held for abort_cyc and abort_cyc+1.
    task automatic run_op(input logic [31:0] x, input int ign_cyc, input int abort_cyc,
                          input int window);
        @(posedge clk); #1;
        radicand = x;
        start    = 1'b1;
        abort    = 1'b0;
        for (int j = 0; j < 3; j++) begin
            got_cyc[j] = -1; pulses[j] = 0; got_res[j] = '0; got_rem[j] = '0;
            rdy_post[j] = 1'b0; rdy_snap[j] = 1'b0;
        end
        for (int k = 1; k <= window; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                if (got_cyc[j] >= 0 && k == got_cyc[j] + 1) rdy_post[j] = ready_v[j];
                if (abort_cyc > 0 && k == abort_cyc + 2) rdy_snap[j] = ready_v[j];
                if (done_v[j]) begin
                    pulses[j]++;
                    if (got_cyc[j] < 0) begin
                        got_cyc[j] = k; got_res[j] = res_v[j]; got_rem[j] = rem_v[j];
                    end
                end
            end
            start = (k == ign_cyc);
            abort = (abort_cyc > 0) && (k == abort_cyc || k == abort_cyc + 1);
            if (k == ign_cyc) radicand = 32'd1000000;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (ready_v[j] !== 1'b1 || done_v[j] !== 1'b0 || res_v[j] !== 16'd0 || rem_v[j] !== 17'd0) begin
                n_bad++;
                $display("FAIL reset[%0d]: ready=%b done=%b result=%h rem=%h, want 1 0 0 0",
                         j, ready_v[j], done_v[j], res_v[j], rem_v[j]);
            end
        end
    endtask

    task automatic test_known;
        logic [31:0] xs [4] = '{32'hFFFF_FFFF, 32'd1000000, 32'd99, 32'd1};
        logic [15:0] rs [4] = '{16'hFFFF, 16'd1000, 16'd9, 16'd1};
        logic [16:0] ms [4] = '{17'h1FFFE, 17'd0, 17'd18, 17'd0};
        for (int v = 0; v < 4; v++) begin
            run_op(xs[v], -1, 0, 20);
            for (int j = 0; j < 3; j++) begin
                n_vec++;
                if (got_res[j] !== rs[v] || got_rem[j] !== ms[v]) begin
                    n_bad++;
                    $display("FAIL known[%0d] x=%h: result=%h rem=%h, want %h %h",
                             j, xs[v], got_res[j], got_rem[j], rs[v], ms[v]);
                end
                n_vec++;
                if (got_cyc[j] !== lat[j] || pulses[j] !== 1) begin
                    n_bad++;
                    $display("FAIL known_lat[%0d] x=%h: done cycle %0d pulses %0d, want %0d 1",
                             j, xs[v], got_cyc[j], pulses[j], lat[j]);
                end
                n_vec++;
                if (rdy_post[j] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: ready after done=%b, want 1", j, rdy_post[j]);
                end
            end
        end
    endtask

    task automatic test_zero;
        run_op(32'd0, -1, 0, 6);
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (got_cyc[j] !== 1 || pulses[j] !== 1 || got_res[j] !== 16'd0 || got_rem[j] !== 17'd0) begin
                n_bad++;
                $display("FAIL zero[%0d]: cycle %0d pulses %0d result=%h rem=%h, want 1 1 0 0",
                         j, got_cyc[j], pulses[j], got_res[j], got_rem[j]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        run_op(32'd99, 3, 0, 20);
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (got_cyc[j] !== lat[j] || pulses[j] !== 1 || got_res[j] !== 16'd9 || got_rem[j] !== 17'd18) begin
                n_bad++;
                $display("FAIL busy_ignore[%0d]: cycle %0d pulses %0d result=%h rem=%h, want %0d 1 9 12",
                         j, got_cyc[j], pulses[j], got_res[j], got_rem[j], lat[j]);
            end
        end
    endtask

    task automatic test_abort;
        run_op(32'd1000000, -1, 0, 20);
        // abort in cycle 4 (still BUSY for every variant), then abort+start together in cycle 5
        run_op(32'hFFFF_FFFF, 5, 4, 20);
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (pulses[j] !== 0) begin
                n_bad++;
                $display("FAIL abort_done[%0d]: %0d done pulses, want 0", j, pulses[j]);
            end
            n_vec++;
            if (rdy_snap[j] !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_ready[%0d]: ready=%b after abort+start, want 1", j, rdy_snap[j]);
            end
            n_vec++;
            if (res_v[j] !== 16'd1000 || rem_v[j] !== 17'd0) begin
                n_bad++;
                $display("FAIL abort_hold[%0d]: result=%h rem=%h, want 3e8 0", j, res_v[j], rem_v[j]);
            end
        end
        run_op(32'd99, -1, 0, 20);
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (got_cyc[j] !== lat[j] || got_res[j] !== 16'd9 || got_rem[j] !== 17'd18) begin
                n_bad++;
                $display("FAIL after_abort[%0d]: cycle %0d result=%h rem=%h, want %0d 9 12",
                         j, got_cyc[j], got_res[j], got_rem[j], lat[j]);
            end
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        radicand = 32'hFFFF_FFFF;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (ready_v[j] !== 1'b1 || done_v[j] !== 1'b0 || res_v[j] !== 16'd0 || rem_v[j] !== 17'd0) begin
                n_bad++;
                $display("FAIL async_reset[%0d]: ready=%b done=%b result=%h rem=%h, want 1 0 0 0",
                         j, ready_v[j], done_v[j], res_v[j], rem_v[j]);
            end
        end
        #2 rst = 1'b0;
        for (int j = 0; j < 3; j++) pulses[j] = 0;
        repeat (20) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) if (done_v[j]) pulses[j]++;
        end
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (pulses[j] !== 0 || ready_v[j] !== 1'b1) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: %0d done pulses ready=%b, want 0 1", j, pulses[j], ready_v[j]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] x;
        longint      r, rr, r1;
        for (int t = 0; t < 2000; t++) begin
            case (t)
                0: x = 32'd2;
                1: x = 32'd3;
                2: x = 32'd4;
                3: x = 32'hFFFE_0001;
                4: x = 32'hFFFE_0000;
                default: x = $urandom() >> $urandom_range(0, 31);
            endcase
            run_op(x, -1, 0, 18);
            for (int j = 0; j < 3; j++) begin
                r  = longint'(got_res[j]);
                rr = r * r;
                r1 = (r + 1) * (r + 1);
                n_vec++;
                if (got_cyc[j] !== (x == 0 ? 1 : lat[j]) || !(rr <= longint'(x) && longint'(x) < r1) ||
                    longint'(got_rem[j]) != longint'(x) - rr) begin
                    n_bad++;
                    $display("FAIL random[%0d] x=%h: cycle %0d result=%h rem=%h, want cycle %0d root^2<=x<(root+1)^2 rem=x-root^2",
                             j, x, got_cyc[j], got_res[j], got_rem[j], (x == 0 ? 1 : lat[j]));
                end
            end
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        test_reset();
        test_known();
        test_zero();
        test_busy_ignore();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
